tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer: the receive end of the 4:1 channel multiplexing scheme in the combinational-circuit library. A serial word stream of interleaved channel samples, with a sync flag on channel 0, is split back into four registered parallel outputs. The block tracks frame alignment with a small FSM and flags sync loss. It sits downstream of any 4:1 mux/serialiser that emits words in order ch0, ch1, ch2, ch3.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_demux_ctrl.sv | 106 ++++++++++
 rtl/tdm_demux4.sv | 58 +++++
 tb/tb_tdm_demux4.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel multiplexing scheme (demux and future serialiser).
package tdm_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_W   = $clog2(NUM_CH);

   typedef enum logic {
      HUNT,
      LOCKED
   } state_e;

   // One-hot decode of a channel index.
   function automatic logic [NUM_CH-1:0] chan_onehot(input logic [CH_W-1:0] idx);
      logic [NUM_CH-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/tdm_demux_ctrl.sv
// Frame-alignment controller: tracks expected channel, emits channel write enables and
// registered strobe/frame/error/lock indications.
module tdm_demux_ctrl
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sync,
   output logic [NUM_CH-1:0] wr_en,
   output logic [NUM_CH-1:0] out_valid,
   output logic              frame_valid,
   output logic              sync_err,
   output logic              locked
);

   state_e            state_q, state_d;
   logic [CH_W-1:0]   cnt_q, cnt_d;
   logic              frame_ok_q, frame_ok_d;
   logic              frame_d, err_d;

   // State, counter and registered output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         cnt_q       <= '0;
         frame_ok_q  <= 1'b0;
         out_valid   <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_ok_q  <= frame_ok_d;
         out_valid   <= wr_en;
         frame_valid <= frame_d;
         sync_err    <= err_d;
      end
   end

   // Next-state: alignment FSM and next expected channel.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      frame_ok_d = frame_ok_q;
      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (in_sync) begin
                  state_d    = LOCKED;
                  cnt_d      = CH_W'(1);
                  frame_ok_d = 1'b1;
               end
            end
            LOCKED: begin
               if (in_sync) begin
                  // Sync always restarts a clean frame, early or not.
                  cnt_d      = CH_W'(1);
                  frame_ok_d = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d    = HUNT;
                  cnt_d      = '0;
                  frame_ok_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CH_W'(1);
                  if (cnt_q == CH_W'(NUM_CH - 1)) begin
                     frame_ok_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: channel write enable and pulse conditions for the current sample.
   always_comb begin
      wr_en   = '0;
      frame_d = 1'b0;
      err_d   = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (in_sync) begin
                  wr_en = chan_onehot('0);
               end
            end
            LOCKED: begin
               if (in_sync) begin
                  wr_en = chan_onehot('0);
                  err_d = (cnt_q != '0);
               end else if (cnt_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  wr_en   = chan_onehot(cnt_q);
                  frame_d = (cnt_q == CH_W'(NUM_CH - 1)) && frame_ok_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign locked = (state_q == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: splits an interleaved sample stream into registered
// per-channel outputs under control of the frame-alignment FSM.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sync,
   input  logic [WIDTH-1:0]  in_data,
   output logic [WIDTH-1:0]  out0,
   output logic [WIDTH-1:0]  out1,
   output logic [WIDTH-1:0]  out2,
   output logic [WIDTH-1:0]  out3,
   output logic [NUM_CH-1:0] out_valid,
   output logic              frame_valid,
   output logic              locked,
   output logic              sync_err
);

   logic [NUM_CH-1:0] wr_en;
   logic [WIDTH-1:0]  ch_q [NUM_CH];

   tdm_demux_ctrl u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sync     (in_sync),
      .wr_en       (wr_en),
      .out_valid   (out_valid),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .locked      (locked)
   );

   // Channel holding registers, each written only when its enable is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
               ch_q[i] <= in_data;
            end
         end
      end
   end

   assign out0 = ch_q[0];
   assign out1 = ch_q[1];
   assign out2 = ch_q[2];
   assign out3 = ch_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
module tb_tdm_demux4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_sync;
   logic [7:0] in_data;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] out_valid;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   int n_checks = 0;
   int n_fail   = 0;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sync     (in_sync),
      .in_data     (in_data),
      .out0        (out0),
      .out1        (out1),
      .out2        (out2),
      .out3        (out3),
      .out_valid   (out_valid),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] exp);
      check($sformatf("%s outs", tag), {out3, out2, out1, out0}, exp);
   endtask

   // Drive one cycle of input at the falling edge, check registered results after the rise.
   task automatic step(input string tag, input logic v, input logic s, input logic [7:0] d,
                       input logic [3:0] e_ov, input logic e_fv, input logic e_err,
                       input logic e_lock);
      @(negedge clk);
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      @(posedge clk);
      #1;
      check($sformatf("%s out_valid", tag), 32'(out_valid), 32'(e_ov));
      check($sformatf("%s frame_valid", tag), 32'(frame_valid), 32'(e_fv));
      check($sformatf("%s sync_err", tag), 32'(sync_err), 32'(e_err));
      check($sformatf("%s locked", tag), 32'(locked), 32'(e_lock));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset frame_valid", 32'(frame_valid), 32'h0);
      check("reset locked", 32'(locked), 32'h0);
      check("reset sync_err", 32'(sync_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Clean frame, continuous valid.
      step("a0", 1, 1, 8'hA0, 4'b0001, 0, 0, 1);
      step("a1", 1, 0, 8'h11, 4'b0010, 0, 0, 1);
      step("a2", 1, 0, 8'h22, 4'b0100, 0, 0, 1);
      step("a3", 1, 0, 8'h33, 4'b1000, 1, 0, 1);
      check_outs("a", 32'h332211A0);
      step("aidle", 0, 0, 8'hFF, 4'b0000, 0, 0, 1);

      // Missing sync after a full frame: error, drop to HUNT, nothing captured.
      step("ms", 1, 0, 8'h77, 4'b0000, 0, 1, 0);
      check_outs("ms", 32'h332211A0);
      step("msidle", 0, 0, 8'h00, 4'b0000, 0, 0, 0);

      // HUNT discards unsynced words quietly, then acquires on sync.
      step("h0", 1, 0, 8'h55, 4'b0000, 0, 0, 0);
      step("h1", 1, 0, 8'h66, 4'b0000, 0, 0, 0);
      check_outs("h", 32'h332211A0);
      step("b0", 1, 1, 8'h01, 4'b0001, 0, 0, 1);
      step("b1", 1, 0, 8'h02, 4'b0010, 0, 0, 1);
      step("b2", 1, 0, 8'h03, 4'b0100, 0, 0, 1);
      step("b3", 1, 0, 8'h04, 4'b1000, 1, 0, 1);
      check_outs("b", 32'h04030201);

      // Early sync abandons partial frame; next full frame completes.
      step("c0", 1, 1, 8'h01, 4'b0001, 0, 0, 1);
      step("c1", 1, 0, 8'h02, 4'b0010, 0, 0, 1);
      step("ce", 1, 1, 8'h09, 4'b0001, 0, 1, 1);
      check_outs("ce", 32'h04030209);
      step("c2", 1, 0, 8'h0A, 4'b0010, 0, 0, 1);
      step("c3", 1, 0, 8'h0B, 4'b0100, 0, 0, 1);
      step("c4", 1, 0, 8'h0C, 4'b1000, 1, 0, 1);
      check_outs("c", 32'h0C0B0A09);

      // Frame with gaps: valid every third cycle.
      step("g0", 1, 1, 8'h10, 4'b0001, 0, 0, 1);
      step("g0i", 0, 0, 8'hEE, 4'b0000, 0, 0, 1);
      step("g0j", 0, 1, 8'hEE, 4'b0000, 0, 0, 1);
      step("g1", 1, 0, 8'h20, 4'b0010, 0, 0, 1);
      step("g1i", 0, 0, 8'hEE, 4'b0000, 0, 0, 1);
      step("g1j", 0, 0, 8'hEE, 4'b0000, 0, 0, 1);
      step("g2", 1, 0, 8'h30, 4'b0100, 0, 0, 1);
      step("g2i", 0, 0, 8'hEE, 4'b0000, 0, 0, 1);
      step("g2j", 0, 0, 8'hEE, 4'b0000, 0, 0, 1);
      step("g3", 1, 0, 8'h40, 4'b1000, 1, 0, 1);
      check_outs("g", 32'h40302010);

      // Asynchronous reset mid-frame.
      step("r0", 1, 1, 8'h5A, 4'b0001, 0, 0, 1);
      step("r1", 1, 0, 8'h5B, 4'b0010, 0, 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_outs("rst async", 32'h0);
      check("rst async locked", 32'(locked), 32'h0);
      check("rst async out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step("r2", 1, 0, 8'hC3, 4'b0000, 0, 0, 0);
      step("r3", 1, 0, 8'hC4, 4'b0000, 0, 0, 0);
      check_outs("rpost", 32'h0);
      step("r4", 1, 1, 8'hD1, 4'b0001, 0, 0, 1);
      check_outs("racq", 32'h000000D1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
